// File: rtl/spad_stream_packer.sv
// rtl/spad_stream_packer.sv - packs spad_manager pixel groups into AXI4-Stream packets
//
// One packet per frame: a header beat (frame number and duration), then the data beats,
// with TLAST on the last one. An output FIFO absorbs M_AXIS back-pressure. When the FIFO
// runs out of room mid-frame the packet is cut short by a flagged terminator beat. When
// there is no room at a frame's first read the whole frame is refused.
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   ReadEnable                 PixelIn0..3 valid this cycle (no upstream back-pressure)
//   PixelIn0..PixelIn3         4-pixel group, PixelIn0 lands in the low byte
//   FrameDurationCurrentClks   copied into each header beat
//   M_AXIS_TDATA/TKEEP/TUSER/TLAST/TVALID/TREADY
//                              stream out; TUSER[0]=terminator, TUSER[1]=header
//   FrameCounter               frames started (wraps)
//   DroppedFrames              truncated or refused frames (saturates)
//   Overflow                   one-cycle pulse per truncation/refusal
module spad_stream_packer #(
  parameter int DATA_WIDTH      = 64,
  parameter int READS_PER_FRAME = 1024,
  parameter int DURATION_BITS   = 32,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ReadEnable,
  input  logic [7:0]               PixelIn0,
  input  logic [7:0]               PixelIn1,
  input  logic [7:0]               PixelIn2,
  input  logic [7:0]               PixelIn3,
  input  logic [DURATION_BITS-1:0] FrameDurationCurrentClks,
  output logic [DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0]  M_AXIS_TKEEP,
  output logic [1:0]               M_AXIS_TUSER,
  output logic                     M_AXIS_TLAST,
  output logic                     M_AXIS_TVALID,
  input  logic                     M_AXIS_TREADY,
  output logic [31:0]              FrameCounter,
  output logic [15:0]              DroppedFrames,
  output logic                     Overflow
);

  localparam int WPB    = DATA_WIDTH / 32;
  localparam int SLOT_W = $clog2(WPB);
  localparam int RCNT_W = $clog2(READS_PER_FRAME);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BEAT_W = DATA_WIDTH + 3;  // {tuser, tlast, tdata}

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  state_t                  state_q, state_d;
  logic [RCNT_W-1:0]       rcnt_q;
  logic [DATA_WIDTH-33:0]  pack_q;         // slots 0..WPB-2; the last slot comes straight from the input
  logic [31:0]             frame_cnt_q;
  logic [15:0]             dropped_q;
  logic                    overflow_q;

  logic [BEAT_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          count_q;

  logic [31:0]             pix_word;
  logic [SLOT_W-1:0]       slot;
  logic                    last_read;
  logic                    space;
  logic                    fifo_valid;
  logic                    pop;
  logic [BEAT_W-1:0]       head;
  logic [DATA_WIDTH-1:0]   hdr_data;

  logic                    push;
  logic [BEAT_W-1:0]       push_beat;
  logic                    inc_frame;
  logic                    drop_evt;

  assign pix_word   = {PixelIn3, PixelIn2, PixelIn1, PixelIn0};
  assign slot       = rcnt_q[SLOT_W-1:0];
  assign last_read  = (rcnt_q == RCNT_W'(READS_PER_FRAME - 1));
  // Last FIFO slot is reserved so a terminator can always be written.
  assign space      = (count_q < (PTR_W+1)'(FIFO_DEPTH - 1));
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid & M_AXIS_TREADY;
  assign head       = mem[rd_ptr_q];

  always_comb begin
    hdr_data = '0;
    hdr_data[31:0] = frame_cnt_q + 32'd1;
    hdr_data[32 +: DURATION_BITS] = FrameDurationCurrentClks;
  end

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    push_beat = '0;
    inc_frame = 1'b0;
    drop_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ReadEnable) begin
          inc_frame = 1'b1;
          if (space) begin
            push      = 1'b1;
            push_beat = {2'b10, 1'b0, hdr_data};
            state_d   = ACTIVE;
          end else begin
            drop_evt = 1'b1;
            state_d  = DROP;
          end
        end
      end
      ACTIVE: begin
        if (ReadEnable && slot == SLOT_W'(WPB - 1)) begin
          push = 1'b1;
          if (space) begin
            push_beat = {2'b00, last_read, pix_word, pack_q};
            if (last_read) state_d = IDLE;
          end else begin
            push_beat = {2'b01, 1'b1, {DATA_WIDTH{1'b0}}};
            drop_evt  = 1'b1;
            // A terminator on the frame's final read has nothing left to discard.
            state_d   = last_read ? IDLE : DROP;
          end
        end
      end
      DROP: begin
        if (ReadEnable && last_read) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rcnt_q      <= '0;
      pack_q      <= '0;
      frame_cnt_q <= '0;
      dropped_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= drop_evt;
      if (ReadEnable) rcnt_q <= last_read ? '0 : rcnt_q + RCNT_W'(1);
      for (int k = 0; k < WPB - 1; k++) begin
        if (ReadEnable && slot == SLOT_W'(k)) pack_q[32*k +: 32] <= pix_word;
      end
      if (inc_frame) frame_cnt_q <= frame_cnt_q + 32'd1;
      if (drop_evt && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_beat;
  end

  assign M_AXIS_TVALID = fifo_valid;
  assign M_AXIS_TDATA  = fifo_valid ? head[DATA_WIDTH-1:0] : '0;
  assign M_AXIS_TLAST  = fifo_valid & head[DATA_WIDTH];
  assign M_AXIS_TUSER  = fifo_valid ? head[DATA_WIDTH+2:DATA_WIDTH+1] : 2'b00;
  assign M_AXIS_TKEEP  = fifo_valid ? '1 : '0;
  assign FrameCounter  = frame_cnt_q;
  assign DroppedFrames = dropped_q;
  assign Overflow      = overflow_q;

endmodule

// File: tb/tb_spad_stream_packer.sv
// tb/tb_spad_stream_packer.sv - scoreboard testbench for spad_stream_packer
module tb_spad_stream_packer;

  localparam int READS      = 1024;
  localparam int TRUNC_DATA = 14;  // data beats fitting before the reserved slot (header + 14 = 15)
  localparam int NORMAL     = 0;
  localparam int TRUNC      = 1;
  localparam int REFUSED    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_en = 1'b0;
  logic [7:0]  pix0 = '0, pix1 = '0, pix2 = '0, pix3 = '0;
  logic [31:0] dur = '0;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [1:0]  tuser;
  logic        tlast, tvalid;
  logic        tready = 1'b1;
  logic [31:0] frame_counter;
  logic [15:0] dropped;
  logic        overflow;

  int tests = 0;
  int fails = 0;
  int beats_seen = 0;
  int tlast_cnt = 0;
  int ovf_cnt = 0;
  logic [31:0] fc_exp = '0;
  logic [63:0] first_data = '0;
  logic [66:0] exp_q[$];
  bit          stall_prev = 1'b0;
  logic [66:0] stall_beat = '0;

  always #5 clk = ~clk;

  spad_stream_packer dut (
    .clk                      (clk),
    .reset                    (rst),
    .ReadEnable               (read_en),
    .PixelIn0                 (pix0),
    .PixelIn1                 (pix1),
    .PixelIn2                 (pix2),
    .PixelIn3                 (pix3),
    .FrameDurationCurrentClks (dur),
    .M_AXIS_TDATA             (tdata),
    .M_AXIS_TKEEP             (tkeep),
    .M_AXIS_TUSER             (tuser),
    .M_AXIS_TLAST             (tlast),
    .M_AXIS_TVALID            (tvalid),
    .M_AXIS_TREADY            (tready),
    .FrameCounter             (frame_counter),
    .DroppedFrames            (dropped),
    .Overflow                 (overflow)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 128'(tvalid), 128'(1));
        check("stall_stable", 128'({tuser, tlast, tdata}), 128'(stall_beat));
      end
      if (tvalid && tready) begin
        if (beats_seen == 1) first_data = tdata;
        beats_seen++;
        if (tlast) tlast_cnt++;
        check("tkeep", 128'(tkeep), 128'(8'hFF));
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got %h expected none", {tuser, tlast, tdata});
        end else begin
          check("beat", 128'({tuser, tlast, tdata}), 128'(exp_q.pop_front()));
        end
      end
      stall_prev = tvalid && !tready;
      stall_beat = {tuser, tlast, tdata};
      if (overflow) ovf_cnt++;
    end
  end

  task automatic run_frame(input int mode, input int nreads, input bit toggle);
    logic [31:0] w, w_prev;
    int ndata;
    bit termed;
    fc_exp = fc_exp + 32'd1;
    dur = 32'hD00D_0000 + fc_exp;
    if (mode != REFUSED) exp_q.push_back({2'b10, 1'b0, dur, fc_exp});
    ndata = 0;
    termed = 1'b0;
    w_prev = '0;
    for (int i = 0; i < nreads; i++) begin
      read_en = 1'b1;
      pix0 = 8'(i);
      pix1 = 8'(i + 1);
      pix2 = 8'(i + 2);
      pix3 = 8'(i + 3);
      w = {pix3, pix2, pix1, pix0};
      if (i % 2 == 1) begin
        if (mode == NORMAL) begin
          exp_q.push_back({2'b00, (i == READS - 1), w, w_prev});
        end else if (mode == TRUNC && !termed) begin
          if (ndata < TRUNC_DATA) begin
            exp_q.push_back({2'b00, 1'b0, w, w_prev});
            ndata++;
          end else begin
            exp_q.push_back({2'b01, 1'b1, 64'd0});
            termed = 1'b1;
          end
        end
      end
      w_prev = w;
      if (toggle) tready = ~tready;
      step();
    end
    read_en = 1'b0;
  endtask

  task automatic drain();
    int n;
    tready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_tvalid", 128'(tvalid), 128'(0));
    check("rst_outputs", 128'({tdata, tkeep, tuser, tlast, overflow}), 128'(0));
    check("rst_frame_counter", 128'(frame_counter), 128'(0));
    check("rst_dropped", 128'(dropped), 128'(0));
    rst = 1'b0;
    step();

    // 1: unstalled full frame
    tready = 1'b1;
    run_frame(NORMAL, READS, 1'b0);
    drain();
    check("t1_beats", 128'(beats_seen), 128'(513));
    check("t1_tlast_cnt", 128'(tlast_cnt), 128'(1));
    check("t1_first_data", 128'(first_data), 128'(64'h04030201_03020100));
    check("t1_frame_counter", 128'(frame_counter), 128'(1));
    check("t1_ovf", 128'(ovf_cnt), 128'(0));

    // 2: stalled stream truncates the frame
    tready = 1'b0;
    run_frame(TRUNC, READS, 1'b0);
    check("t2_ovf", 128'(ovf_cnt), 128'(1));
    check("t2_dropped", 128'(dropped), 128'(1));
    check("t2_frame_counter", 128'(frame_counter), 128'(2));

    // 3: one beat drained leaves 15 held, so the next frame is refused
    tready = 1'b1;
    step();
    tready = 1'b0;
    run_frame(REFUSED, READS, 1'b0);
    check("t3_ovf", 128'(ovf_cnt), 128'(2));
    check("t3_dropped", 128'(dropped), 128'(2));
    check("t3_frame_counter", 128'(frame_counter), 128'(3));
    drain();

    // 4: TREADY toggling every cycle; header shows counter 4 after the refused frame 3
    tready = 1'b1;
    run_frame(NORMAL, READS, 1'b1);
    drain();
    check("t4_frame_counter", 128'(frame_counter), 128'(4));
    check("t4_ovf", 128'(ovf_cnt), 128'(2));

    // 5: reset at read 300
    run_frame(NORMAL, 300, 1'b0);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("t5_tvalid", 128'(tvalid), 128'(0));
    check("t5_frame_counter", 128'(frame_counter), 128'(0));
    check("t5_dropped", 128'(dropped), 128'(0));
    step();
    rst = 1'b0;
    fc_exp = '0;
    ovf_cnt = 0;
    step();
    run_frame(NORMAL, READS, 1'b0);
    drain();
    check("t5_frame_counter_after", 128'(frame_counter), 128'(1));

    // 6: DroppedFrames saturation
    tready = 1'b0;
    run_frame(TRUNC, READS, 1'b0);
    check("t6_dropped_first", 128'(dropped), 128'(1));
    force dut.dropped_q = 16'hFFFE;
    step();
    release dut.dropped_q;
    run_frame(REFUSED, READS, 1'b0);
    check("t6_dropped_ffff", 128'(dropped), 128'(16'hFFFF));
    run_frame(REFUSED, READS, 1'b0);
    check("t6_dropped_sat", 128'(dropped), 128'(16'hFFFF));
    check("t6_frame_counter", 128'(frame_counter), 128'(4));
    check("t6_ovf", 128'(ovf_cnt), 128'(3));
    drain();
    check("final_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
